// File: rtl/fluxo_dados_rodada_if.sv
// Bus between the game control unit and the round datapath.
// The master side drives the player buttons and strobes; the slave side returns the status flags.
interface fluxo_dados_rodada_if #(
    parameter int N      = 4,
    parameter int ADDR_W = 4
);
    logic [N-1:0]      chaves;
    logic              zeraR;
    logic              registraR;
    logic              zeraE;
    logic              contaE;
    logic              zeraL;
    logic              contaL;
    logic              zeraT;
    logic              contaT;
    logic              jogada_igual;
    logic              jogada_valida;
    logic              enderecoIgualLimite;
    logic              fimE;
    logic              fimL;
    logic              timeout;
    logic              jogada_feita;
    logic              db_tem_jogada;
    logic [N-1:0]      db_jogada;
    logic [ADDR_W-1:0] db_contagem;
    logic [ADDR_W-1:0] db_limite;
    logic [N-1:0]      db_memoria;

    modport master (
        output chaves, zeraR, registraR, zeraE, contaE, zeraL, contaL, zeraT, contaT,
        input  jogada_igual, jogada_valida, enderecoIgualLimite, fimE, fimL, timeout,
               jogada_feita, db_tem_jogada, db_jogada, db_contagem, db_limite, db_memoria
    );

    modport slave (
        input  chaves, zeraR, registraR, zeraE, contaE, zeraL, contaL, zeraT, contaT,
        output jogada_igual, jogada_valida, enderecoIgualLimite, fimE, fimL, timeout,
               jogada_feita, db_tem_jogada, db_jogada, db_contagem, db_limite, db_memoria
    );
endinterface

// File: rtl/fluxo_dados_rodada.sv
// Round datapath for the memory-sequence game: address/limit counters, play timer,
// play register, one-hot check, press edge detector and a registered-read sequence ROM.
module fluxo_dados_rodada #(
    parameter int N       = 4,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 5000
) (
    input  logic                 clock,
    input  logic                 reset,
    fluxo_dados_rodada_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]     T_MAX = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] A_MAX = '1;

    logic [ADDR_W-1:0] e_q, e_d;
    logic [ADDR_W-1:0] l_q, l_d;
    logic [TW-1:0]     t_q, t_d;
    logic [N-1:0]      jogada_q, jogada_d;
    logic [N-1:0]      mem_q;
    logic              edge_q;
    logic              tem_jogada;

    // Word i holds a single lit button, cycling through the N positions.
    logic [N-1:0] rom [DEPTH];
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            localparam int SH = gi % N;
            assign rom[gi] = N'(1) << SH;
        end
    endgenerate

    always_comb begin
        e_d      = e_q;
        l_d      = l_q;
        t_d      = t_q;
        jogada_d = jogada_q;
        if (bus.zeraE)       e_d = '0;
        else if (bus.contaE) e_d = e_q + 1'b1;
        if (bus.zeraL)       l_d = '0;
        else if (bus.contaL) l_d = l_q + 1'b1;
        // Timer saturates so timeout stays asserted until explicitly cleared.
        if (bus.zeraT)                        t_d = '0;
        else if (bus.contaT && (t_q < T_MAX)) t_d = t_q + 1'b1;
        if (bus.zeraR)          jogada_d = '0;
        else if (bus.registraR) jogada_d = bus.chaves;
    end

    assign tem_jogada = |bus.chaves;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_q      <= '0;
            l_q      <= '0;
            t_q      <= '0;
            jogada_q <= '0;
            mem_q    <= '0;
            edge_q   <= 1'b0;
        end else begin
            e_q      <= e_d;
            l_q      <= l_d;
            t_q      <= t_d;
            jogada_q <= jogada_d;
            mem_q    <= rom[e_q];
            edge_q   <= tem_jogada;
        end
    end

    assign bus.jogada_igual        = (mem_q == jogada_q);
    assign bus.jogada_valida       = (jogada_q != '0) && ((jogada_q & (jogada_q - 1'b1)) == '0);
    assign bus.enderecoIgualLimite = (e_q == l_q);
    assign bus.fimE                = (e_q == A_MAX);
    assign bus.fimL                = (l_q == A_MAX);
    assign bus.timeout             = (t_q == T_MAX);
    assign bus.jogada_feita        = tem_jogada & ~edge_q;
    assign bus.db_tem_jogada       = tem_jogada;
    assign bus.db_jogada           = jogada_q;
    assign bus.db_contagem         = e_q;
    assign bus.db_limite           = l_q;
    assign bus.db_memoria          = mem_q;
endmodule
